// File: rtl/xilinx_phy10g_reset_seq_if.sv
// Control/status bundle between the 10G PHY reset sequencer (slave) and its
// environment (master): QPLL/GT status in, reset and ready strobes out.
interface xilinx_phy10g_reset_seq_if #(
   parameter int NUM_LANES   = 8,
   parameter int MAX_RETRIES = 3
);
   localparam int RC_W = $clog2(MAX_RETRIES + 1);

   logic                 qplllock_i;
   logic [NUM_LANES-1:0] lane_en_i;
   logic [NUM_LANES-1:0] tx_resetdone_i;
   logic [NUM_LANES-1:0] rx_resetdone_i;
   logic [NUM_LANES-1:0] rx_reset_req_i;
   logic                 qpllreset_o;
   logic                 gttxreset_o;
   logic [NUM_LANES-1:0] gtrxreset_o;
   logic                 txuserrdy_o;
   logic [NUM_LANES-1:0] lane_ready_o;
   logic                 all_ready_o;
   logic                 fail_o;
   logic [RC_W-1:0]      retry_cnt_o;
   logic [2:0]           state_o;

   modport master (
      output qplllock_i, lane_en_i, tx_resetdone_i, rx_resetdone_i, rx_reset_req_i,
      input  qpllreset_o, gttxreset_o, gtrxreset_o, txuserrdy_o, lane_ready_o,
             all_ready_o, fail_o, retry_cnt_o, state_o
   );

   modport slave (
      input  qplllock_i, lane_en_i, tx_resetdone_i, rx_resetdone_i, rx_reset_req_i,
      output qpllreset_o, gttxreset_o, gtrxreset_o, txuserrdy_o, lane_ready_o,
             all_ready_o, fail_o, retry_cnt_o, state_o
   );
endinterface

// File: rtl/xilinx_phy10g_reset_seq.sv
// QPLL / GT reset sequencer for NUM_LANES 10G lanes: hold-off, QPLL reset with
// lock timeout and bounded retries, GT reset, lock-loss recovery, per-lane RX reset.
module xilinx_phy10g_reset_seq #(
   parameter int NUM_LANES    = 8,
   parameter int HOLDOFF_W    = 8,
   parameter int PULSE_CYCLES = 3,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int MAX_RETRIES  = 3
) (
   input logic                     clk156,
   input logic                     gttxreset_txusrclk2,
   xilinx_phy10g_reset_seq_if.slave bus
);
   localparam int RC_W = $clog2(MAX_RETRIES + 1);
   localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
   localparam int PC_W = $clog2(PULSE_CYCLES + 1);

   localparam logic [2:0] HOLDOFF   = 3'd0;
   localparam logic [2:0] QPLL_RST  = 3'd1;
   localparam logic [2:0] WAIT_LOCK = 3'd2;
   localparam logic [2:0] GT_RST    = 3'd3;
   localparam logic [2:0] WAIT_DONE = 3'd4;
   localparam logic [2:0] READY     = 3'd5;
   localparam logic [2:0] FAIL      = 3'd6;

   logic [1:0]           lock_sync;
   logic [NUM_LANES-1:0] txd_m, txd_s, rxd_m, rxd_s;
   logic                 lock_s;

   logic [2:0]           state, state_nxt;
   logic [HOLDOFF_W-1:0] hcnt, hcnt_nxt;
   logic [PC_W-1:0]      pcnt, pcnt_nxt;
   logic [TO_W-1:0]      tcnt, tcnt_nxt;
   logic [RC_W-1:0]      rcnt, rcnt_nxt;
   logic                 done_all, timeout, retry;

   logic                 qpll_r, gttx_r, txu_r, all_r, fail_r;
   logic [NUM_LANES-1:0] gtrx_r, lrdy_r, lrdy_nxt, lrx_nxt;

   always_ff @(posedge clk156 or posedge gttxreset_txusrclk2) begin
      if (gttxreset_txusrclk2) begin
         lock_sync <= '0;
         txd_m     <= '0;
         txd_s     <= '0;
         rxd_m     <= '0;
         rxd_s     <= '0;
      end else begin
         lock_sync <= {lock_sync[0], bus.qplllock_i};
         txd_m     <= bus.tx_resetdone_i;
         txd_s     <= txd_m;
         rxd_m     <= bus.rx_resetdone_i;
         rxd_s     <= rxd_m;
      end
   end

   assign lock_s   = lock_sync[1];
   assign done_all = &(~bus.lane_en_i | (txd_s & rxd_s));
   assign timeout  = (tcnt == TO_W'(LOCK_TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      pcnt_nxt  = pcnt;
      tcnt_nxt  = tcnt;
      rcnt_nxt  = rcnt;
      retry     = 1'b0;
      case (state)
         HOLDOFF: begin
            hcnt_nxt = hcnt + 1'b1;
            if (hcnt_nxt[HOLDOFF_W-1]) begin
               state_nxt = QPLL_RST;
               pcnt_nxt  = '0;
            end
         end
         QPLL_RST, GT_RST: begin
            if (pcnt == PC_W'(PULSE_CYCLES - 1)) begin
               state_nxt = (state == QPLL_RST) ? WAIT_LOCK : WAIT_DONE;
               tcnt_nxt  = '0;
            end else begin
               pcnt_nxt = pcnt + 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt = GT_RST;
               pcnt_nxt  = '0;
            end else if (timeout) retry = 1'b1;
            else tcnt_nxt = tcnt + 1'b1;
         end
         WAIT_DONE: begin
            if (done_all) begin
               state_nxt = READY;
               rcnt_nxt  = '0;
            end else if (timeout) retry = 1'b1;
            else tcnt_nxt = tcnt + 1'b1;
         end
         READY: begin
            // lock loss re-sequences without spending a retry
            if (!lock_s) begin
               state_nxt = QPLL_RST;
               pcnt_nxt  = '0;
            end
         end
         default: state_nxt = FAIL;
      endcase
      if (retry) begin
         rcnt_nxt  = rcnt + 1'b1;
         pcnt_nxt  = '0;
         state_nxt = (rcnt == RC_W'(MAX_RETRIES - 1)) ? FAIL : QPLL_RST;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic            pulse, recov, pulse_nxt, recov_nxt, rdy_nxt;
      logic [PC_W-1:0] lcnt, lcnt_nxt;

      // staying in READY implies lock_s=1, so a request coincident with lock loss is dropped
      always_comb begin
         pulse_nxt = 1'b0;
         recov_nxt = 1'b0;
         lcnt_nxt  = '0;
         rdy_nxt   = 1'b0;
         if (state_nxt == READY && bus.lane_en_i[i]) begin
            if (state != READY) rdy_nxt = 1'b1;
            else if (pulse) begin
               if (lcnt == PC_W'(PULSE_CYCLES - 1)) recov_nxt = 1'b1;
               else begin
                  pulse_nxt = 1'b1;
                  lcnt_nxt  = lcnt + 1'b1;
               end
            end else if (recov) begin
               if (rxd_s[i]) rdy_nxt = 1'b1;
               else recov_nxt = 1'b1;
            end else if (bus.rx_reset_req_i[i]) pulse_nxt = 1'b1;
            else rdy_nxt = lrdy_r[i];
         end
      end

      always_ff @(posedge clk156 or posedge gttxreset_txusrclk2) begin
         if (gttxreset_txusrclk2) begin
            pulse <= 1'b0;
            recov <= 1'b0;
            lcnt  <= '0;
         end else begin
            pulse <= pulse_nxt;
            recov <= recov_nxt;
            lcnt  <= lcnt_nxt;
         end
      end

      assign lrdy_nxt[i] = rdy_nxt;
      assign lrx_nxt[i]  = ~bus.lane_en_i[i] | pulse_nxt |
                           ~(state_nxt inside {WAIT_DONE, READY});
   end

   always_ff @(posedge clk156 or posedge gttxreset_txusrclk2) begin
      if (gttxreset_txusrclk2) begin
         state  <= HOLDOFF;
         hcnt   <= '0;
         pcnt   <= '0;
         tcnt   <= '0;
         rcnt   <= '0;
         qpll_r <= 1'b1;
         gttx_r <= 1'b1;
         gtrx_r <= '1;
         txu_r  <= 1'b0;
         lrdy_r <= '0;
         all_r  <= 1'b0;
         fail_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         hcnt   <= hcnt_nxt;
         pcnt   <= pcnt_nxt;
         tcnt   <= tcnt_nxt;
         rcnt   <= rcnt_nxt;
         qpll_r <= state_nxt inside {HOLDOFF, QPLL_RST, FAIL};
         gttx_r <= ~(state_nxt inside {WAIT_DONE, READY});
         gtrx_r <= lrx_nxt;
         txu_r  <= state_nxt inside {WAIT_DONE, READY};
         lrdy_r <= lrdy_nxt;
         all_r  <= (state_nxt == READY) && (&(lrdy_nxt | ~bus.lane_en_i));
         fail_r <= (state_nxt == FAIL);
      end
   end

   assign bus.qpllreset_o  = qpll_r;
   assign bus.gttxreset_o  = gttx_r;
   assign bus.gtrxreset_o  = gtrx_r;
   assign bus.txuserrdy_o  = txu_r;
   assign bus.lane_ready_o = lrdy_r;
   assign bus.all_ready_o  = all_r;
   assign bus.fail_o       = fail_r;
   assign bus.retry_cnt_o  = rcnt;
   assign bus.state_o      = state;
endmodule
